serial_to_parallel: RTL
=======================

Name: serial_to_parallel

Overview:
Upstream feeder for the bit population counter. Collects a serial bit stream qualified by a valid strobe into WIDTH-bit words. Each completed word, or a partial word forced out by flush, is presented as a one-cycle data/valid pulse that connects directly to the counter's data_i/data_val_i. Partial words are zero-padded, so the downstream population count counts only received bits.

Parameters:
WIDTH, 8, output word width in bits; legal values are 2 and above.
MSB_FIRST, 1, 1: first received bit goes to data_o[WIDTH-1]; 0: first received bit goes to data_o[0].

Ports:
clk_i  input  1  clock; all logic is rising-edge.
rst_n_i  input  1  asynchronous active-low reset.
data_i  input  1  serial data bit; sampled only when data_val_i=1.
data_val_i  input  1  qualifies data_i for the current cycle.
flush_i  input  1  emits the accumulated partial word.
data_o  output  WIDTH  assembled word.
data_len_o  output  $clog2(WIDTH+1)  number of valid bits in data_o, from 1 to WIDTH.
data_val_o  output  1  one-cycle pulse; data_o and data_len_o are valid while it is high.

Behaviour:
- Reset (rst_n_i=0, asynchronous): data_o=0, data_len_o=0, data_val_o=0. Shift register and bit counter are cleared.
- Release of reset is synchronous to clk_i. The first valid bit after release starts a new word.
- A reset asserted mid-word discards the partial word. No output pulse is generated for it.
- Internal state: shift register sr[WIDTH-1:0] and bit counter cnt, range 0..WIDTH-1.
- Bit intake on a cycle with data_val_i=1: the bit is written at position cnt.
  - MSB_FIRST=1: position is index WIDTH-1-cnt.
  - MSB_FIRST=0: position is index cnt.
  - Unwritten positions of the current word are always 0.
- Word complete: the valid bit taken while cnt=WIDTH-1 completes the word. On the next edge:
  - data_o = completed word, data_len_o = WIDTH, data_val_o = 1.
  - cnt wraps to 0 and sr clears to 0.
  - Latency is exactly 1 cycle from the sampling edge of the last bit.
- Back-to-back operation: data_val_i held at 1 continuously gives one pulse every WIDTH cycles with no lost bits and no bubble.
- Flush:
  - Condition: flush_i=1 and (cnt>0 or data_val_i=1).
  - On the next edge: data_o = sr including any bit taken in the same cycle, data_len_o = cnt plus that bit, data_val_o = 1. cnt and sr clear.
  - A bit arriving with data_val_i=1 in the flush cycle is included in the flushed word.
  - flush_i with cnt=0 and data_val_i=0 has no effect: no pulse.
  - flush_i in the cycle that completes a full word produces a single pulse with data_len_o=WIDTH. There is no extra empty pulse.
- Output holding:
  - data_val_o is high for exactly one cycle per word and is 0 otherwise.
  - data_o and data_len_o hold their last emitted values between pulses.
- Idle cycles (data_val_i=0, flush_i=0): state is unchanged. Gaps of any length within a word are allowed.
- No backpressure: the downstream stage accepts every cycle.

Test Plan:
- Reset values: hold rst_n_i=0, then release -> data_o=0, data_len_o=0, data_val_o=0; no pulse without input.
- Full word, WIDTH=8, MSB_FIRST=1: bits 1,0,1,1,0,0,0,1 on consecutive cycles -> one cycle after the 8th bit: data_o=8'hB1, data_len_o=8, data_val_o pulse of 1 cycle.
- Full word with MSB_FIRST=0: same bit sequence -> data_o=8'h8D. Then insert random idle gaps within the word -> identical result.
- Streaming: 24 continuous valid bits forming A5, 3C, FF -> three pulses spaced exactly 8 cycles apart with data_o=A5, 3C, FF; no lost bits.
- Flush:
  - 3 bits 1,1,0 then flush_i alone -> data_o=8'hC0, data_len_o=3.
  - flush_i with cnt=0 -> no pulse.
  - flush_i coinciding with the 8th bit -> single pulse, data_len_o=8.
  - flush_i together with a 4th bit 1 after bits 1,0,1 -> data_o=8'hB0, data_len_o=4.
- Async reset mid-word: 5 bits, assert rst_n_i between clock edges -> outputs clear immediately. After release, 8 new bits produce a word with no leftover bits.

Source files
------------

// File: rtl/serial_to_parallel.sv
// serial_to_parallel
//   Collects a serial bit stream, qualified by a valid strobe, into WIDTH-bit
//   words. A word is emitted when it fills up, or early as a zero-padded
//   partial word when flush is requested. The output is a one-cycle
//   data/valid pulse, with the number of received bits given in data_len_o.
//
// Parameters
//   WIDTH      output word width (>= 2)
//   MSB_FIRST  1: first received bit lands in data_o[WIDTH-1]
//              0: first received bit lands in data_o[0]
//
// Ports
//   clk_i       rising-edge clock
//   rst_n_i     asynchronous active-low reset
//   data_i      serial data bit, sampled when data_val_i=1
//   data_val_i  qualifies data_i
//   flush_i     emit the accumulated partial word
//   data_o      assembled word (held between pulses)
//   data_len_o  number of valid bits in data_o (1..WIDTH)
//   data_val_o  one-cycle pulse marking a new data_o/data_len_o
module serial_to_parallel #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned LW       = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             data_i,
  input  logic             data_val_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LW-1:0]    data_len_o,
  output logic             data_val_o
);

  localparam logic [LW-1:0] LAST = LW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, sr_w;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]    len_q, len_d;
  logic             val_q, val_d;
  logic [LW-1:0]    pos;
  logic [LW-1:0]    fill;
  logic             emit;

  always_comb begin
    // Word as it stands after this cycle's intake; emitted words are taken
    // from here so a bit arriving alongside flush is included.
    sr_w = sr_q;
    pos  = MSB_FIRST ? (LAST - cnt_q) : cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data_val_i && (LW'(i) == pos)) begin
        sr_w[i] = data_i;
      end
    end
    fill = cnt_q + LW'(data_val_i);

    // A full word and a flush in the same cycle collapse into one pulse.
    emit = (data_val_i && (cnt_q == LAST)) ||
           (flush_i && ((cnt_q != '0) || data_val_i));

    sr_d   = sr_w;
    cnt_d  = fill;
    data_d = data_q;
    len_d  = len_q;
    val_d  = 1'b0;

    if (emit) begin
      sr_d   = '0;
      cnt_d  = '0;
      data_d = sr_w;
      len_d  = fill;
      val_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      len_q  <= '0;
      val_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      len_q  <= len_d;
      val_q  <= val_d;
    end
  end

  assign data_o     = data_q;
  assign data_len_o = len_q;
  assign data_val_o = val_q;

endmodule
